// File: rtl/hop_cnt_rr_arbiter.sv
// Packet-locking switch arbiter: highest hop count wins, round-robin among ties,
// with a per-input wait counter that forces starving inputs ahead of hop priority.
module hop_cnt_rr_arbiter #(
    parameter  int IN_N       = 5,
    parameter  int HOP_CNT_W  = 3,
    parameter  int STARVE_LIM = 15,
    localparam int WAIT_W     = $clog2(STARVE_LIM + 1),
    localparam int ID_W       = $clog2(IN_N)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [IN_N-1:0]           req_i,
    input  logic [IN_N*HOP_CNT_W-1:0] hop_cnt_i,
    input  logic                      done_i,
    output logic [IN_N-1:0]           gnt_o,
    output logic [ID_W-1:0]           gnt_id_o,
    output logic                      gnt_vld_o,
    output logic                      tie_o,
    output logic                      starve_o
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state, state_nxt;
    logic [ID_W-1:0]        rr_ptr;
    logic [WAIT_W-1:0]      wait_cnt [IN_N];
    logic [HOP_CNT_W-1:0]   hop      [IN_N];
    logic [HOP_CNT_W-1:0]   max_hop;
    logic [IN_N-1:0]        starve_mask;
    logic [IN_N-1:0]        max_mask;
    logic [IN_N-1:0]        cand;
    logic [ID_W-1:0]        win_id;
    logic                   any_req;
    logic                   any_starve;
    logic                   multi_cand;
    logic                   arb_ev;
    logic                   grant_ev;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v == WAIT_W'(STARVE_LIM)) ? v : v + WAIT_W'(1);
    endfunction

    function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] id);
        return (id == ID_W'(IN_N - 1)) ? '0 : id + ID_W'(1);
    endfunction

    assign any_req  = |req_i;
    assign arb_ev   = ((state == IDLE) && any_req) || ((state == LOCKED) && done_i);
    assign grant_ev = arb_ev && any_req;

    always_comb begin
        max_hop     = '0;
        starve_mask = '0;
        max_mask    = '0;
        for (int i = 0; i < IN_N; i++) begin
            hop[i]         = hop_cnt_i[i*HOP_CNT_W +: HOP_CNT_W];
            starve_mask[i] = req_i[i] && (wait_cnt[i] == WAIT_W'(STARVE_LIM));
            if (req_i[i] && (hop[i] > max_hop))
                max_hop = hop[i];
        end
        for (int i = 0; i < IN_N; i++)
            max_mask[i] = req_i[i] && (hop[i] == max_hop);
        any_starve = |starve_mask;
        cand       = any_starve ? starve_mask : max_mask;
        multi_cand = |(cand & (cand - IN_N'(1)));
    end

    // Cyclic search for the first candidate at or after rr_ptr
    always_comb begin
        int  idx;
        logic found;
        win_id = '0;
        found  = 1'b0;
        for (int k = 0; k < IN_N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= IN_N)
                idx = idx - IN_N;
            if (!found && cand[idx]) begin
                found  = 1'b1;
                win_id = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (arb_ev)
            state_nxt = any_req ? LOCKED : IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_o    <= '0;
            gnt_id_o <= '0;
            tie_o    <= 1'b0;
            starve_o <= 1'b0;
            rr_ptr   <= '0;
        end else if (grant_ev) begin
            gnt_o    <= IN_N'(1) << win_id;
            gnt_id_o <= win_id;
            tie_o    <= multi_cand;
            starve_o <= any_starve;
            rr_ptr   <= ptr_after(win_id);
        end else if (arb_ev) begin
            gnt_o    <= '0;
            gnt_id_o <= '0;
            tie_o    <= 1'b0;
            starve_o <= 1'b0;
        end
    end

    // The holder's counter is held rather than advanced: it is waiting on its own packet
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < IN_N; i++)
                wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < IN_N; i++) begin
                if (!req_i[i] || (grant_ev && (win_id == ID_W'(i))))
                    wait_cnt[i] <= '0;
                else if (!gnt_o[i])
                    wait_cnt[i] <= sat_inc(wait_cnt[i]);
            end
        end
    end

    assign gnt_vld_o = (state == LOCKED);

endmodule

// File: tb/tb_hop_cnt_rr_arbiter.sv
// Scoreboard bench for hop_cnt_rr_arbiter: directed scenarios plus random traffic
// checked against a queue-based reference model of the arbitration rules.
module tb_hop_cnt_rr_arbiter;

    localparam int IN_N       = 5;
    localparam int HOP_CNT_W  = 3;
    localparam int STARVE_LIM = 3;
    localparam int ID_W       = $clog2(IN_N);

    typedef struct {
        logic [IN_N-1:0] gnt;
        logic [ID_W-1:0] id;
        logic            vld;
        logic            tie;
        logic            st;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [IN_N-1:0]           req = '0;
    logic [IN_N*HOP_CNT_W-1:0] hop = '0;
    logic                      done = 1'b0;
    logic [IN_N-1:0]           gnt;
    logic [ID_W-1:0]           gnt_id;
    logic                      gnt_vld;
    logic                      tie;
    logic                      starve;

    int n_cmp = 0;
    int n_bad = 0;
    int n_starve_grants = 0;
    exp_t sb [$];

    // reference model state
    bit m_vld, m_tie, m_st;
    int m_gid, m_rr;
    int m_wait [IN_N];

    hop_cnt_rr_arbiter #(.IN_N(IN_N), .HOP_CNT_W(HOP_CNT_W), .STARVE_LIM(STARVE_LIM)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .hop_cnt_i(hop), .done_i(done),
        .gnt_o(gnt), .gnt_id_o(gnt_id), .gnt_vld_o(gnt_vld), .tie_o(tie), .starve_o(starve)
    );

    always #5 clk = ~clk;

    function automatic logic [IN_N*HOP_CNT_W-1:0] mk_hop(input int h0, h1, h2, h3, h4);
        return {3'(h4), 3'(h3), 3'(h2), 3'(h1), 3'(h0)};
    endfunction

    function automatic void model_reset();
        m_vld = 0; m_tie = 0; m_st = 0; m_gid = 0; m_rr = 0;
        for (int i = 0; i < IN_N; i++) m_wait[i] = 0;
    endfunction

    function automatic void model_step();
        int hv [IN_N];
        int cands [$];
        int best, win, bestd, d;
        bit any_st, ev, grant;
        best = -1; any_st = 0; win = 0; bestd = IN_N;
        for (int i = 0; i < IN_N; i++) begin
            hv[i] = int'(hop[i*HOP_CNT_W +: HOP_CNT_W]);
            if (req[i] && m_wait[i] == STARVE_LIM) any_st = 1;
            if (req[i] && hv[i] > best) best = hv[i];
        end
        for (int i = 0; i < IN_N; i++)
            if (req[i] && (any_st ? (m_wait[i] == STARVE_LIM) : (hv[i] == best)))
                cands.push_back(i);
        // winner = candidate with the smallest cyclic distance from the pointer
        foreach (cands[k]) begin
            d = (cands[k] - m_rr + IN_N) % IN_N;
            if (d < bestd) begin bestd = d; win = cands[k]; end
        end
        ev    = m_vld ? bit'(done) : (req != 0);
        grant = ev && (req != 0);
        for (int i = 0; i < IN_N; i++) begin
            if (!req[i] || (grant && win == i)) m_wait[i] = 0;
            else if (!(m_vld && m_gid == i) && m_wait[i] < STARVE_LIM) m_wait[i]++;
        end
        if (grant) begin
            m_vld = 1; m_gid = win; m_tie = (cands.size() > 1); m_st = any_st;
            m_rr = (win + 1) % IN_N;
        end else if (ev) begin
            m_vld = 0; m_gid = 0; m_tie = 0; m_st = 0;
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.gnt = m_vld ? IN_N'(1) << m_gid : '0;
        e.id  = m_vld ? ID_W'(m_gid) : '0;
        e.vld = m_vld; e.tie = m_tie; e.st = m_st;
        sb.push_back(e);
    endfunction

    task automatic cyc(input logic [IN_N-1:0] r, input logic [IN_N*HOP_CNT_W-1:0] h, input logic d);
        req = r; hop = h; done = d;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        push_exp();
        #1;
    endtask

    // Monitor: one expected record per cycle, compared away from the active edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (gnt_vld && starve) n_starve_grants++;
            if ({gnt, gnt_id, gnt_vld, tie, starve} !== {e.gnt, e.id, e.vld, e.tie, e.st}) begin
                n_bad++;
                $display("FAIL outputs t=%0t: got gnt=%b id=%0d vld=%b tie=%b st=%b, want gnt=%b id=%0d vld=%b tie=%b st=%b",
                         $time, gnt, gnt_id, gnt_vld, tie, starve, e.gnt, e.id, e.vld, e.tie, e.st);
            end
        end
    end

    initial begin
        model_reset();
        // reset state
        cyc('0, '0, 1'b0);
        cyc(5'b00111, '0, 1'b1);
        rst_n = 1'b1;

        // single maximum
        cyc(5'b10110, mk_hop(0, 2, 5, 0, 3), 1'b0);
        cyc(5'b00000, '0, 1'b1);
        cyc(5'b00000, '0, 1'b0);

        // park rr_ptr at 0 by granting input 4, then round-robin ties
        cyc(5'b10000, '0, 1'b0);
        cyc(5'b00000, '0, 1'b1);
        cyc(5'b11111, mk_hop(4, 4, 4, 4, 4), 1'b0);
        repeat (6) cyc(5'b11111, mk_hop(4, 4, 4, 4, 4), 1'b1);
        cyc(5'b00000, '0, 1'b1);

        // lock hold against a higher-hop newcomer
        cyc(5'b00001, mk_hop(1, 0, 0, 0, 0), 1'b0);
        repeat (5) cyc(5'b01001, mk_hop(1, 0, 0, 7, 0), 1'b0);
        cyc(5'b01001, mk_hop(1, 0, 0, 7, 0), 1'b1);
        cyc(5'b01000, mk_hop(1, 0, 0, 7, 0), 1'b0);
        cyc(5'b00000, '0, 1'b1);

        // starvation: hop-0 input 0 against hop-7 input 1 with 2-cycle packets
        for (int k = 0; k < 16; k++)
            cyc(5'b00011, mk_hop(0, 7, 0, 0, 0), 1'(k % 2));
        cyc(5'b00000, '0, 1'b1);
        n_cmp++;
        if (n_starve_grants == 0) begin
            n_bad++;
            $display("FAIL starve_seen: got %0d starve grants, want at least 1", n_starve_grants);
        end

        // idle and empty
        repeat (3) cyc(5'b00000, '0, 1'b1);
        cyc(5'b00100, '0, 1'b0);
        cyc(5'b00000, '0, 1'b1);
        cyc(5'b00000, '0, 1'b0);

        // asynchronous reset mid-lock
        cyc(5'b00100, mk_hop(0, 0, 6, 0, 0), 1'b0);
        cyc(5'b00110, mk_hop(0, 0, 6, 0, 0), 1'b0);
        #6;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({gnt, gnt_id, gnt_vld, tie, starve} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got gnt=%b id=%0d vld=%b tie=%b st=%b, want all 0",
                     gnt, gnt_id, gnt_vld, tie, starve);
        end
        #1;
        rst_n = 1'b1;
        cyc(5'b00011, mk_hop(2, 2, 0, 0, 0), 1'b0);
        cyc(5'b00011, mk_hop(2, 2, 0, 0, 0), 1'b1);
        cyc(5'b00000, '0, 1'b1);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            logic [IN_N-1:0] r;
            logic [IN_N*HOP_CNT_W-1:0] h;
            r = IN_N'($urandom) & IN_N'($urandom | $urandom);
            for (int i = 0; i < IN_N; i++)
                h[i*HOP_CNT_W +: HOP_CNT_W] = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 2));
            cyc(r, h, ($urandom_range(0, 2) == 0));
        end
        cyc(5'b00000, '0, 1'b1);

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hop_cnt_rr_arbiter.md
# hop_cnt_rr_arbiter

Registered, packet-locking switch arbiter that grants the requesting input with the highest hop count, for any number of inputs and any hop-count width. Ties are broken round-robin. A per-input wait counter overrides hop-count priority once an input has waited too long. It sits in each router output port, between the input-buffer head-flit decode and the crossbar select, and holds its grant until the downstream logic signals that the packet's tail flit has been transferred.

## Interface
Parameters:
- IN_N, 5, number of requesting inputs; must be >= 2
- HOP_CNT_W, 3, hop-count field width; must be >= 1
- STARVE_LIM, 15, number of waiting cycles after which an input becomes starving; must be >= 1
- WAIT_W (localparam), $clog2(STARVE_LIM+1), width of each wait counter

Ports (one clock; reset is asynchronous and active-low):
- clk_i, input, 1, clock
- rst_ni, input, 1, asynchronous active-low reset
- req_i, input, IN_N, per-input head-flit request
- hop_cnt_i, input, IN_N*HOP_CNT_W, input i's hop count at bits [HOP_CNT_W*(i+1)-1 : HOP_CNT_W*i]
- done_i, input, 1, tail flit of the granted packet transferred this cycle
- gnt_o, output, IN_N, one-hot grant, registered
- gnt_id_o, output, $clog2(IN_N), index of the granted input, registered
- gnt_vld_o, output, 1, a grant is held
- tie_o, output, 1, the current grant was decided by round-robin among equal candidates
- starve_o, output, 1, the current grant was issued through the starvation override

## Operation
- State machine has two states:
  - IDLE: no grant held.
  - LOCKED: grant held.
- An arbitration event occurs at a clock edge when either:
  - state is IDLE and req_i != 0, or
  - state is LOCKED and done_i = 1.
  If the event finds req_i != 0, a new grant is issued and the state becomes or stays LOCKED. If req_i = 0, the state goes to IDLE and all outputs clear.
- Candidate set, from req_i sampled at the event:
  - If any requesting input is starving (wait[i] == STARVE_LIM), the candidates are exactly the starving inputs, and hop count is ignored.
  - Otherwise, the candidates are the requesting inputs whose hop count equals the maximum hop count among requesting inputs.
  - Non-requesting inputs never take part. A hop count of 0 from a requesting input is a legal value.
  - Hop counts are compared unsigned. All-ones is a legal maximum.
- Winner: the first candidate at or after rr_ptr, searching cyclically (rr_ptr, rr_ptr+1, … wrapping from IN_N-1 to 0).
  - tie_o = 1 if there is more than one candidate.
  - starve_o = 1 if the starvation override applied.
- rr_ptr: on every grant, set to (winner+1) mod IN_N. Otherwise held.
- Wait counters, per input, updated every cycle:
  - Cleared when req_i[i] = 0, or when input i is granted at this edge.
  - Else incremented when req_i[i] = 1 and input i is not the current holder of gnt_o.
  - Saturate at STARVE_LIM.
- While LOCKED:
  - gnt_o, gnt_id_o, tie_o and starve_o are frozen.
  - req_i changes, including the holder dropping its request, do not release the lock. Only done_i releases it.
- done_i in IDLE is ignored.

## Timing
- Reset (rst_ni low, asynchronous): gnt_o = 0, gnt_id_o = 0, gnt_vld_o = 0, tie_o = 0, starve_o = 0, rr_ptr = 0, all wait counters = 0, state = IDLE. Outputs go to these values immediately on assertion, without waiting for a clock edge.
- Latency: a request seen in IDLE at edge N appears on gnt_o after edge N.
- done_i at edge N with pending requests: the new grant appears after the same edge N, with no bubble. The previous winner is now lowest priority among ties because rr_ptr has advanced past it.
- Reset released mid-packet: the arbiter starts in IDLE and re-arbitrates. Rebuilding packet state is upstream's responsibility.
- All outputs are driven from flops. There is no combinational path from req_i, hop_cnt_i or done_i to any output.

## Test plan
- Single maximum: IN_N=5, req_i=5'b10110, hop counts in1=2, in2=5, in4=3, in IDLE. After one edge: gnt_o=5'b00100, gnt_id_o=2, gnt_vld_o=1, tie_o=0, starve_o=0.
- Round-robin tie: req_i=5'b11111, all hop counts = 4, rr_ptr=0. First grant goes to input 0 with tie_o=1. Pulsing done_i once per cycle then yields grants 1, 2, 3, 4, 0 on consecutive edges.
- Lock hold: input 0 is granted with hop 1. Input 3 then requests with hop 7. gnt_o stays 5'b00001 until done_i; after the done_i edge, gnt_o=5'b01000.
- Starvation: STARVE_LIM=3. Input 0 (hop 0) and input 1 (hop 7) request continuously, with a 2-cycle packet for input 1 (done_i every second cycle). Input 1 wins until wait[0] reaches 3. The next event then grants input 0 with starve_o=1, and wait[0] returns to 0.
- Idle and empty: done_i pulses with req_i=0 leave all outputs at 0. done_i with req_i=0 while LOCKED returns to IDLE, and gnt_vld_o=0 after that edge.
- Asynchronous reset mid-lock: rst_ni is pulled low between edges while LOCKED. All outputs are 0 before the next edge. After release with req_i=5'b00011 and equal hop counts, input 0 is granted because rr_ptr was reset to 0.
